fp_adder: RTL and testbench

- IEEE-754 binary32 adder: s = a + b, round-to-nearest-ties-to-even.
- Full subnormal support on inputs and outputs; no flush-to-zero.
- Combinational datapath with a single output register stage.
- Used as a standalone arithmetic leaf in FP datapaths.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_adder.sv | 137 +++++++++++++
 tb/tb_fp_adder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 format constants, the fp32_t view of a word, and
// classification helpers used by the adder datapath.
package fp_pkg;

    localparam int          EXP_W    = 8;
    localparam int          FRAC_W   = 23;
    localparam int          EXP_BIAS = 127;
    localparam int          SIG_W    = 27;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac != 23'd0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac == 23'd0);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the 27-bit working significand
// (hidden + fraction + guard/round/sticky); an all-zero input yields 27.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    output logic [4:0]       count
);

    // Scan upward so the most significant set bit determines the count.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < SIG_W; i++) begin
            count = sig[i] ? 5'(SIG_W - 1 - i) : count;
        end
    end

endmodule

// File: rtl/fp_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, full subnormal support.
// Combinational datapath followed by a single output register.
module fp_adder
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    fp32_t       a_s;
    fp32_t       b_s;
    fp32_t       big_s;
    fp32_t       sml_s;
    logic        swap_s;
    logic [7:0]  big_exp_s;
    logic [7:0]  sml_exp_s;
    logic [7:0]  diff_s;
    logic [23:0] big_sig_s;
    logic [23:0] sml_sig_s;
    logic [49:0] sml_wide_s;
    logic [26:0] big_ext_s;
    logic [26:0] sml_ext_s;
    logic        eff_sub_s;
    logic [27:0] raw_s;
    logic [26:0] mag_s;
    logic [8:0]  exp_pre_s;
    logic [8:0]  max_sh_s;
    logic [8:0]  exp_norm_s;
    logic [4:0]  lz_s;
    logic [4:0]  sh_s;
    logic [26:0] norm_s;
    logic [7:0]  exp_field_s;
    logic        inc_s;
    logic [30:0] rnd_s;
    logic [31:0] finite_s;
    logic [31:0] sum_s;
    logic [31:0] s_r;

    assign a_s = a;
    assign b_s = b;

    // Order by magnitude and align the smaller significand with G/R/S bits.
    always_comb begin
        swap_s    = ({b_s.exp, b_s.frac} > {a_s.exp, a_s.frac});
        big_s     = swap_s ? b_s : a_s;
        sml_s     = swap_s ? a_s : b_s;
        big_exp_s = (big_s.exp == 8'd0) ? 8'd1 : big_s.exp;
        sml_exp_s = (sml_s.exp == 8'd0) ? 8'd1 : sml_s.exp;
        big_sig_s = {(big_s.exp != 8'd0), big_s.frac};
        sml_sig_s = {(sml_s.exp != 8'd0), sml_s.frac};
        diff_s    = big_exp_s - sml_exp_s;
        big_ext_s = {big_sig_s, 3'b000};
        eff_sub_s = big_s.sign ^ sml_s.sign;
        // 26 extra bits below the significand cover every shift that
        // still leaves something in the guard or round position.
        sml_wide_s = {sml_sig_s, 26'd0} >> diff_s;
        if (diff_s >= 8'd26) begin
            sml_ext_s = {26'd0, (sml_sig_s != 24'd0)};
        end else begin
            sml_ext_s = {sml_wide_s[49:24], |sml_wide_s[23:0]};
        end
    end

    // Magnitude add or subtract; a carry-out folds one bit into sticky.
    always_comb begin
        if (eff_sub_s) begin
            raw_s = {1'b0, big_ext_s - sml_ext_s};
        end else begin
            raw_s = {1'b0, big_ext_s} + {1'b0, sml_ext_s};
        end
        if (raw_s[27]) begin
            mag_s     = {raw_s[27:2], raw_s[1] | raw_s[0]};
            exp_pre_s = {1'b0, big_exp_s} + 9'd1;
        end else begin
            mag_s     = raw_s[26:0];
            exp_pre_s = {1'b0, big_exp_s};
        end
    end

    fp_lzc u_lzc (
        .sig   (mag_s),
        .count (lz_s)
    );

    // Normalise without letting the exponent fall below 1, then round RNE.
    always_comb begin
        max_sh_s    = exp_pre_s - 9'd1;
        sh_s        = ({4'd0, lz_s} <= max_sh_s) ? lz_s : max_sh_s[4:0];
        norm_s      = mag_s << sh_s;
        exp_norm_s  = exp_pre_s - {4'd0, sh_s};
        exp_field_s = norm_s[26] ? exp_norm_s[7:0] : 8'd0;
        inc_s       = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        // A rounding carry ripples into the exponent field, which also turns
        // a maximal subnormal into the smallest normal.
        rnd_s       = {exp_field_s, norm_s[25:3]} + {30'd0, inc_s};
    end

    // Finite-result packing: exact cancellation, overflow, regular sum.
    always_comb begin
        if (eff_sub_s && (mag_s == 27'd0)) begin
            finite_s = 32'd0;
        end else if ((exp_norm_s >= 9'd255) || (rnd_s[30:23] == EXP_MAX)) begin
            finite_s = {big_s.sign, POS_INF[30:0]};
        end else begin
            finite_s = {big_s.sign, rnd_s};
        end
    end

    // Special operands override the arithmetic path.
    always_comb begin
        if (is_nan(a_s) || is_nan(b_s) ||
            (is_inf(a_s) && is_inf(b_s) && (a_s.sign != b_s.sign))) begin
            sum_s = QNAN;
        end else if (is_inf(a_s)) begin
            sum_s = a_s;
        end else if (is_inf(b_s)) begin
            sum_s = b_s;
        end else begin
            sum_s = finite_s;
        end
    end

    // Output register; reset wins over the freshly computed sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= 32'd0;
        end else begin
            s_r <= sum_s;
        end
    end

    assign s = s_r;

endmodule

// File: tb/tb_fp_adder.sv
// Scoreboard bench for fp_adder: directed corner cases plus a randomised
// sweep checked against a real-arithmetic binary32 reference model.
module tb_fp_adder;
    import fp_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          vectors;
    int          miscompares;

    fp_adder dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .s   (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real to_real(input logic [31:0] x);
        real m;
        if (x[30:23] == 8'd0) begin
            m = real'(x[22:0]) * (2.0 ** real'(1 - EXP_BIAS - 23));
        end else begin
            m = real'({1'b1, x[22:0]}) * (2.0 ** real'(int'(x[30:23]) - EXP_BIAS - 23));
        end
        return x[31] ? -m : m;
    endfunction

    // Round a nonzero double (exact enough: double rounding is harmless for
    // a single addition) to binary32 with ties-to-even.
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] db;
        logic [63:0] m;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic [63:0] mag;
        int          e;
        int          shift;
        db = $realtobits(r);
        e  = int'(db[62:52]) - 1023;
        m  = {11'd0, 1'b1, db[51:0]};
        shift = (e >= -126) ? 29 : 29 + (-126 - e);
        if (shift >= 60) return {db[63], 31'd0};
        kept = m >> shift;
        rem  = m & ((64'd1 << shift) - 64'd1);
        half = 64'd1 << (shift - 1);
        if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 64'd1;
        mag = (e >= -126) ? ((64'(e + 126) << 23) + kept) : kept;
        if (mag >= 64'(POS_INF)) return {db[63], POS_INF[30:0]};
        return {db[63], mag[30:0]};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic xnan, ynan, xinf, yinf;
        real  rs;
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (xnan || ynan) return QNAN;
        if (xinf && yinf) return (x[31] != y[31]) ? QNAN : x;
        if (xinf) return x;
        if (yinf) return y;
        rs = to_real(x) + to_real(y);
        if (rs == 0.0) begin
            if ((x[30:0] == 31'd0) && (y[30:0] == 31'd0)) return {x[31] & y[31], 31'd0};
            return 32'd0;
        end
        return to_f32(rs);
    endfunction

    task automatic apply(input logic r, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want, input string name);
        rst = r;
        a   = x;
        b   = y;
        exp_q.push_back(want);
        tag_q.push_back($sformatf("%s %h+%h", name, x, y));
        @(negedge clk);
    endtask

    // Monitor: one result per cycle, compared just after the capturing edge.
    always @(posedge clk) begin
        logic [31:0] want;
        string       tag;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            vectors++;
            if (s !== want) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", tag, s, want);
            end
        end
    end

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 7))
            0:       e = 8'd0;
            1:       e = 8'd1;
            2:       e = 8'd254;
            3:       e = 8'd255;
            default: e = 8'($urandom_range(0, 255));
        endcase
        f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    initial begin
        logic [31:0] da [17];
        logic [31:0] db [17];
        logic [31:0] de [17];
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  ye;
        vectors     = 0;
        miscompares = 0;
        da = '{32'h3F800001, 32'h3F800001, 32'h40000000, 32'h34000001, 32'h407fffff,
               32'h00012832, 32'h00b627be, 32'h01925662, 32'h12e1798b, 32'h121f73da,
               32'h00000000, 32'h7F800000, 32'h7F7FFFFF, 32'h80000000, 32'h00000000,
               32'h7FC00001, 32'h7F800000};
        db = '{32'hBF800000, 32'hBF800001, 32'h34000000, 32'h40000000, 32'h34000000,
               32'h8014283c, 32'h000a21a8, 32'h81b81010, 32'h121f73da, 32'h12e1798b,
               32'h440d491c, 32'hFF800000, 32'h7F7FFFFF, 32'h80000000, 32'h80000000,
               32'h3F800000, 32'h3F800000};
        de = '{32'h34000000, 32'h00000000, 32'h40000000, 32'h40000001, 32'h40800000,
               32'h8013000a, 32'h00c04966, 32'h8096e6b8, 32'h131899bc, 32'h131899bc,
               32'h440d491c, 32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000,
               32'h7FC00000, 32'h7F800000};

        apply(1'b1, 32'h440d491c, 32'h4d064db7, 32'h00000000, "reset");
        apply(1'b0, 32'h440d491c, 32'h4d064db7, 32'h4d064dda, "after_reset");
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, da[i], db[i], de[i], $sformatf("directed%0d", i));
        end
        // Reset mid-stream must override a live sum.
        apply(1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, "reset_mid");

        for (int i = 0; i < 3000; i++) begin
            x = rand_op();
            if ($urandom_range(0, 3) == 0) begin
                ye = x[30:23] + 8'($urandom_range(0, 2)) - 8'd1;
                y  = {~x[31], ye, x[22:0] ^ 23'($urandom_range(0, 15))};
            end else begin
                y = rand_op();
            end
            apply(1'b0, x, y, ref_add(x, y), "random");
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
